mem_responder: RTL

Memory-side responder for the CPU controller's bus: it answers the controller's `rd`/`wr` strobes with registered read data and synchronous writes to a 32×8 word store. It also owns a boot-loader port that streams a program image into memory while holding the CPU in reset. It can reload a new image after the CPU halts. It sits between the controller/address mux and the program/data store, and it drives the CPU's reset.

---
 rtl/mem_responder_if.sv | 36 +++
 rtl/mem_responder.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/mem_responder_if.sv
// Bus bundle between the controller side and mem_responder:
// CPU read/write strobes, boot-loader stream and status flags.
interface mem_responder_if #(
  parameter int AW = 5,
  parameter int DW = 8
);
  logic [AW-1:0] addr;
  logic          rd;
  logic          wr;
  logic [DW-1:0] wdata;
  logic          halt;
  logic [DW-1:0] rdata;
  logic          rdata_vld;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          cpu_rst;
  logic          boot_done;
  logic          coll_err;
  logic          wp_err;

  modport master (
    output addr, rd, wr, wdata, halt,
    output ld_valid, ld_data, ld_last,
    input  rdata, rdata_vld, ld_ready,
    input  cpu_rst, boot_done, coll_err, wp_err
  );

  modport slave (
    input  addr, rd, wr, wdata, halt,
    input  ld_valid, ld_data, ld_last,
    output rdata, rdata_vld, ld_ready,
    output cpu_rst, boot_done, coll_err, wp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Memory responder: boot-loader image streaming plus CPU rd/wr service.
// Optional write protection via MEM_RESPONDER_WRPROTECT_EN.
module mem_responder #(
  parameter int AW         = 5,
  parameter int DW         = 8,
  parameter int PROT_LIMIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  mem_responder_if.slave bus
);
  localparam int DEPTH = 1 << AW;

  typedef enum logic {
    LOAD,
    SERVE
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] ptr_q, ptr_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          vld_q, vld_d;
  logic          rdy_q, rdy_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          boot_q, boot_d;
  logic          coll_q, coll_d;
  logic          wp_q, wp_d;

  logic [DW-1:0] mem_q [DEPTH];
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdat;
  logic          ld_hs;

`ifdef MEM_RESPONDER_WRPROTECT_EN
  localparam logic [AW:0] ProtLim = PROT_LIMIT[AW:0];
  logic prot_hit;
  assign prot_hit = {1'b0, bus.addr} < ProtLim;
`else
  localparam int unused_prot_limit = PROT_LIMIT;
`endif

  assign ld_hs = (state_q == LOAD) && bus.ld_valid && rdy_q;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    vld_d   = 1'b0;
    coll_d  = coll_q;
    wp_d    = wp_q;
    we      = 1'b0;
    waddr   = ptr_q;
    wdat    = bus.ld_data;
    unique case (state_q)
      LOAD: begin
        if (ld_hs) begin
          we = 1'b1;
          if (bus.ld_last || (ptr_q == '1)) begin
            state_d = SERVE;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      SERVE: begin
        if (bus.wr) begin
          waddr = bus.addr;
          wdat  = bus.wdata;
`ifdef MEM_RESPONDER_WRPROTECT_EN
          if (prot_hit) begin
            wp_d = 1'b1;
          end else begin
            we = 1'b1;
          end
`else
          we = 1'b1;
`endif
        end
        // write wins a collision; the read is simply dropped
        if (bus.rd && bus.wr) begin
          coll_d = 1'b1;
        end
        if (bus.rd && !bus.wr) begin
          vld_d   = 1'b1;
          rdata_d = mem_q[bus.addr];
        end
        // reload beat is not consumed here; ld_ready rises first
        if (bus.halt && bus.ld_valid) begin
          state_d = LOAD;
          ptr_d   = '0;
        end
      end
      default: state_d = LOAD;
    endcase
    rdy_d     = (state_d == LOAD);
    cpu_rst_d = (state_d == LOAD);
    boot_d    = (state_d == SERVE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= LOAD;
      ptr_q     <= '0;
      rdata_q   <= '0;
      vld_q     <= 1'b0;
      rdy_q     <= 1'b0;
      cpu_rst_q <= 1'b1;
      boot_q    <= 1'b0;
      coll_q    <= 1'b0;
      wp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      rdata_q   <= rdata_d;
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
      cpu_rst_q <= cpu_rst_d;
      boot_q    <= boot_d;
      coll_q    <= coll_d;
      wp_q      <= wp_d;
    end
  end

  // contents survive reset; only the write is gated
  always_ff @(posedge clk) begin
    if (rst_n && we) begin
      mem_q[waddr] <= wdat;
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.rdata_vld = vld_q;
  assign bus.ld_ready  = rdy_q;
  assign bus.cpu_rst   = cpu_rst_q;
  assign bus.boot_done = boot_q;
  assign bus.coll_err  = coll_q;
`ifdef MEM_RESPONDER_WRPROTECT_EN
  assign bus.wp_err    = wp_q;
`else
  assign bus.wp_err    = 1'b0;
`endif
endmodule
